seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
- Runtime-programmable, parametrised successor to the fixed 3-bit / 8-symbol sequence detector.
- Watches a qualified symbol stream and pulses seq_found when the last LEN accepted symbols equal a programmed pattern.
- Supports overlapping or non-overlapping detection and keeps a saturating match counter.
- Sits between the symbol source and the control/status logic.

Parameters:
DATA_W, 3, symbol width in bits
MAX_LEN, 8, maximum pattern length in symbols (>=2)
CNT_W, 16, width of match_count

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  1 = accept symbols; 0 = ignore in_valid, hold history
in_valid  in  1  data holds a symbol this cycle
data  in  DATA_W  input symbol
overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match
cfg_pat_we  in  1  write pattern slot
cfg_idx  in  $clog2(MAX_LEN)  pattern slot index; 0 = first symbol of sequence
cfg_sym  in  DATA_W  pattern symbol to write
cfg_len_we  in  1  write pattern length
cfg_len  in  $clog2(MAX_LEN+1)  pattern length
clr_count  in  1  synchronous clear of match_count
seq_found  out  1  one-cycle match pulse, registered
match_count  out  CNT_W  saturating number of matches
cur_len  out  $clog2(MAX_LEN+1)  active pattern length

Behaviour:
- Reset (async, any time):
  - pat[] = 0, len = 1, history cleared, fill = 0.
  - seq_found = 0, match_count = 0, cur_len = 1.
- Accept condition: enable & in_valid & no config write this cycle.
- On accept:
  - hist shifts; hist[0] = data (newest).
  - fill = min(fill+1, MAX_LEN).
- Match condition, evaluated on the post-shift history: fill_next >= len and hist_next[k] == pat[len-1-k] for all k < len.
- Output timing:
  - seq_found goes high for exactly one cycle after the edge that accepts the final pattern symbol (latency 1 cycle from symbol sample).
  - seq_found is 0 in every cycle without a match, including non-accept cycles.
- Overlap handling:
  - overlap=1: history is untouched after a match; a suffix of the match may begin the next match.
  - overlap=0: fill is forced to 0 on the match edge, so the next match needs len fresh symbols.
  - overlap is sampled on the match edge.
- Config writes:
  - cfg_pat_we writes pat[cfg_idx] = cfg_sym.
  - cfg_len_we writes len. cfg_len = 0 is ignored. cfg_len > MAX_LEN clamps to MAX_LEN.
  - Both writes may occur in the same cycle.
  - Any config write clears fill to 0 (the in-progress partial match is dropped).
  - A symbol arriving in the same cycle as a config write is dropped; no match is possible that cycle.
  - cfg_idx >= MAX_LEN: the write is ignored, but fill is still cleared.
- Pattern slots at index >= len are don't-care.
- enable = 0: history, fill and pattern hold. Config writes are still honoured. seq_found = 0.
- match_count:
  - Increments by 1 on each seq_found edge and saturates at 2^CNT_W-1.
  - clr_count alone sets it to 0.
  - clr_count with a simultaneous match sets it to 1.
- cur_len mirrors the len register.
- len = 1: every accepted symbol equal to pat[0] produces a pulse, in either overlap mode.

Test Plan:
- DATA_W=3, pattern 1,5,6,0,6,6,3,5, len=8, overlap=1. Stream 7,1,5,6,0,6,6,3,5,2 -> seq_found high only in the cycle after the symbol 5 at position 9; match_count=1.
- Pattern 1,1,1, len=3. Stream of five 1s -> overlap=1: pulses after the 3rd, 4th and 5th symbols (count=3). overlap=0: pulse after the 3rd only (count=1).
- Pattern 2,3, len=2. Stream 2, then in_valid=0 for 4 cycles, then 3 -> one pulse after the 3. Repeat with enable=0 during the 3 -> no pulse, history held.
- Pattern 4,4, len=2. Send 4, then a cfg_len_we pulse to 2 with in_valid=1 data=4 in the same cycle, then 4 -> no pulse; symbol dropped and fill cleared. A further 4 -> pulse.
- Mid-sequence: after 5 of 8 matching symbols assert rst for 1 cycle -> seq_found=0, count=0, len=1, pat=0. Subsequent symbol 0 -> pulse (len 1, pat[0]=0).
- CNT_W=2, len=1, pat[0]=0, stream of five 0s -> count 1,2,3,3,3. clr_count with a match in the same cycle -> count=1.

Source files
------------

// File: rtl/seq_detector_prog_if.sv
// Symbol, configuration and status bundle for the programmable sequence detector.
// The master side is the symbol source / control logic; the slave side is the detector.
`timescale 1ns/1ps
interface seq_detector_prog_if #(
    parameter int DATA_W  = 3,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic              enable;
    logic              in_valid;
    logic [DATA_W-1:0] data;
    logic              overlap;
    logic              cfg_pat_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [DATA_W-1:0] cfg_sym;
    logic              cfg_len_we;
    logic [LEN_W-1:0]  cfg_len;
    logic              clr_count;
    logic              seq_found;
    logic [CNT_W-1:0]  match_count;
    logic [LEN_W-1:0]  cur_len;

    modport master (
        output enable, in_valid, data, overlap,
        output cfg_pat_we, cfg_idx, cfg_sym, cfg_len_we, cfg_len, clr_count,
        input  seq_found, match_count, cur_len
    );

    modport slave (
        input  enable, in_valid, data, overlap,
        input  cfg_pat_we, cfg_idx, cfg_sym, cfg_len_we, cfg_len, clr_count,
        output seq_found, match_count, cur_len
    );
endinterface

// File: rtl/seq_detector_prog.sv
// Runtime-programmable sequence detector: compares the newest accepted symbols against
// a programmed pattern and emits a registered one-cycle pulse plus a saturating match count.
`timescale 1ns/1ps
module seq_detector_prog #(
    parameter int DATA_W  = 3,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_prog_if.slave   bus
);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] pat       [MAX_LEN];
    logic [DATA_W-1:0] hist      [MAX_LEN];
    logic [DATA_W-1:0] hist_next [MAX_LEN];
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  fill;
    logic [LEN_W-1:0]  fill_inc;
    logic [LEN_W-1:0]  pidx;
    logic              cfg_write;
    logic              accept;
    logic              hit;
    logic              found;
    logic [CNT_W-1:0]  count;

    assign cfg_write = bus.cfg_pat_we | bus.cfg_len_we;
    assign accept    = bus.enable & bus.in_valid & ~cfg_write;

    always_comb begin
        hist_next[0] = bus.data;
        for (int k = 1; k < MAX_LEN; k++) begin
            hist_next[k] = hist[k-1];
        end
    end

    // hist_next[0] is the newest symbol, so it lines up with the last pattern slot.
    always_comb begin
        pidx     = '0;
        fill_inc = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
        hit      = accept && (fill_inc >= len);
        for (int k = 0; k < MAX_LEN; k++) begin
            pidx = len - LEN_W'(k) - LEN_W'(1);
            if ((LEN_W'(k) < len) && (hist_next[k] != pat[pidx[IDX_W-1:0]])) begin
                hit = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                pat[k] <= '0;
            end
            len <= LEN_W'(1);
        end else begin
            if (bus.cfg_pat_we && (int'(bus.cfg_idx) < MAX_LEN)) begin
                pat[bus.cfg_idx] <= bus.cfg_sym;
            end
            if (bus.cfg_len_we && (bus.cfg_len != '0)) begin
                if (bus.cfg_len > LEN_W'(MAX_LEN)) begin
                    len <= LEN_W'(MAX_LEN);
                end else begin
                    len <= bus.cfg_len;
                end
            end
        end
    end

    // Without overlap the fill count restarts on a match, so stale symbols cannot be reused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                hist[k] <= '0;
            end
            fill <= '0;
        end else if (cfg_write) begin
            fill <= '0;
        end else if (accept) begin
            hist <= hist_next;
            if (hit && !bus.overlap) begin
                fill <= '0;
            end else begin
                fill <= fill_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            found <= 1'b0;
            count <= '0;
        end else begin
            found <= hit;
            if (bus.clr_count) begin
                count <= hit ? CNT_W'(1) : '0;
            end else if (hit && (count != CNT_MAX)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign bus.seq_found   = found;
    assign bus.match_count = count;
    assign bus.cur_len     = len;
endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed self-checking bench for seq_detector_prog: a CNT_W=16 instance for the main
// scenarios and a CNT_W=2 instance for counter saturation.
`timescale 1ns/1ps
module tb_seq_detector_prog;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    seq_detector_prog_if #(.DATA_W(3), .MAX_LEN(8), .CNT_W(16)) bus ();
    seq_detector_prog_if #(.DATA_W(3), .MAX_LEN(8), .CNT_W(2))  bus2 ();

    seq_detector_prog #(.DATA_W(3), .MAX_LEN(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    seq_detector_prog #(.DATA_W(3), .MAX_LEN(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    always #5 clk = ~clk;

    task automatic init_inputs();
        bus.enable = 1'b1;  bus.in_valid = 1'b0;  bus.data = '0;    bus.overlap = 1'b1;
        bus.cfg_pat_we = 1'b0; bus.cfg_idx = '0;  bus.cfg_sym = '0;
        bus.cfg_len_we = 1'b0; bus.cfg_len = '0;  bus.clr_count = 1'b0;
        bus2.enable = 1'b1; bus2.in_valid = 1'b0; bus2.data = '0;   bus2.overlap = 1'b1;
        bus2.cfg_pat_we = 1'b0; bus2.cfg_idx = '0; bus2.cfg_sym = '0;
        bus2.cfg_len_we = 1'b0; bus2.cfg_len = '0; bus2.clr_count = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic write_pat(input logic [2:0] idx, input logic [2:0] sym);
        @(negedge clk); bus.cfg_pat_we = 1'b1; bus.cfg_idx = idx; bus.cfg_sym = sym;
        @(posedge clk); #1; bus.cfg_pat_we = 1'b0;
    endtask

    task automatic write_len(input logic [3:0] len);
        @(negedge clk); bus.cfg_len_we = 1'b1; bus.cfg_len = len;
        @(posedge clk); #1; bus.cfg_len_we = 1'b0;
    endtask

    task automatic program8();
        logic [2:0] p [8] = '{3'd1, 3'd5, 3'd6, 3'd0, 3'd6, 3'd6, 3'd3, 3'd5};
        for (int i = 0; i < 8; i++) write_pat(3'(i), p[i]);
        write_len(4'd8);
    endtask

    task automatic send_sym(input logic [2:0] sym);
        @(negedge clk); bus.in_valid = 1'b1; bus.data = sym;
        @(posedge clk); #1; bus.in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (bus.seq_found !== 1'b0) begin errors++; $display("[TB] FAIL reset_found got %b expected 0", bus.seq_found); end
        checks++; if (bus.match_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", bus.match_count); end
        checks++; if (bus.cur_len !== 4'd1) begin errors++; $display("[TB] FAIL reset_len got %0d expected 1", bus.cur_len); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_full_pattern();
        logic [2:0] s   [10] = '{3'd7, 3'd1, 3'd5, 3'd6, 3'd0, 3'd6, 3'd6, 3'd3, 3'd5, 3'd2};
        logic       exp [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        bus.overlap = 1'b1;
        program8();
        checks++; if (bus.cur_len !== 4'd8) begin errors++; $display("[TB] FAIL full_len got %0d expected 8", bus.cur_len); end
        for (int i = 0; i < 10; i++) begin
            send_sym(s[i]);
            checks++; if (bus.seq_found !== exp[i]) begin errors++; $display("[TB] FAIL full_sym%0d found got %b expected %b", i, bus.seq_found, exp[i]); end
        end
        checks++; if (bus.match_count !== 16'd1) begin errors++; $display("[TB] FAIL full_count got %0d expected 1", bus.match_count); end
    endtask

    task automatic test_overlap();
        logic exp_ov [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic exp_no [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int mode = 1; mode >= 0; mode--) begin
            do_reset();
            bus.overlap = (mode == 1);
            for (int i = 0; i < 3; i++) write_pat(3'(i), 3'd1);
            write_len(4'd3);
            for (int i = 0; i < 5; i++) begin
                send_sym(3'd1);
                checks++;
                if (bus.seq_found !== ((mode == 1) ? exp_ov[i] : exp_no[i])) begin
                    errors++;
                    $display("[TB] FAIL overlap%0d_sym%0d found got %b expected %b", mode, i, bus.seq_found, (mode == 1) ? exp_ov[i] : exp_no[i]);
                end
            end
            checks++;
            if (bus.match_count !== ((mode == 1) ? 16'd3 : 16'd1)) begin
                errors++;
                $display("[TB] FAIL overlap%0d_count got %0d expected %0d", mode, bus.match_count, (mode == 1) ? 3 : 1);
            end
        end
        bus.overlap = 1'b1;
    endtask

    task automatic test_gap_enable();
        do_reset();
        bus.overlap = 1'b1;
        write_pat(3'd0, 3'd2);
        write_pat(3'd1, 3'd3);
        write_len(4'd2);
        send_sym(3'd2);
        checks++; if (bus.seq_found !== 1'b0) begin errors++; $display("[TB] FAIL gap_first got %b expected 0", bus.seq_found); end
        for (int i = 0; i < 4; i++) begin
            idle_cycle();
            checks++; if (bus.seq_found !== 1'b0) begin errors++; $display("[TB] FAIL gap_idle%0d got %b expected 0", i, bus.seq_found); end
        end
        send_sym(3'd3);
        checks++; if (bus.seq_found !== 1'b1) begin errors++; $display("[TB] FAIL gap_match got %b expected 1", bus.seq_found); end
        idle_cycle();
        checks++; if (bus.seq_found !== 1'b0) begin errors++; $display("[TB] FAIL gap_pulse_width got %b expected 0", bus.seq_found); end
        send_sym(3'd2);
        checks++; if (bus.seq_found !== 1'b0) begin errors++; $display("[TB] FAIL en_first got %b expected 0", bus.seq_found); end
        bus.enable = 1'b0;
        send_sym(3'd3);
        checks++; if (bus.seq_found !== 1'b0) begin errors++; $display("[TB] FAIL en_disabled got %b expected 0", bus.seq_found); end
        bus.enable = 1'b1;
        send_sym(3'd3);
        checks++; if (bus.seq_found !== 1'b1) begin errors++; $display("[TB] FAIL en_held got %b expected 1", bus.seq_found); end
        checks++; if (bus.match_count !== 16'd2) begin errors++; $display("[TB] FAIL en_count got %0d expected 2", bus.match_count); end
    endtask

    task automatic test_cfg_collision();
        do_reset();
        write_pat(3'd0, 3'd4);
        write_pat(3'd1, 3'd4);
        write_len(4'd2);
        send_sym(3'd4);
        checks++; if (bus.seq_found !== 1'b0) begin errors++; $display("[TB] FAIL coll_first got %b expected 0", bus.seq_found); end
        @(negedge clk);
        bus.cfg_len_we = 1'b1; bus.cfg_len = 4'd2; bus.in_valid = 1'b1; bus.data = 3'd4;
        @(posedge clk); #1;
        bus.cfg_len_we = 1'b0; bus.in_valid = 1'b0;
        checks++; if (bus.seq_found !== 1'b0) begin errors++; $display("[TB] FAIL coll_dropped got %b expected 0", bus.seq_found); end
        send_sym(3'd4);
        checks++; if (bus.seq_found !== 1'b0) begin errors++; $display("[TB] FAIL coll_refill got %b expected 0", bus.seq_found); end
        send_sym(3'd4);
        checks++; if (bus.seq_found !== 1'b1) begin errors++; $display("[TB] FAIL coll_match got %b expected 1", bus.seq_found); end
        checks++; if (bus.match_count !== 16'd1) begin errors++; $display("[TB] FAIL coll_count got %0d expected 1", bus.match_count); end
        write_len(4'd0);
        checks++; if (bus.cur_len !== 4'd2) begin errors++; $display("[TB] FAIL len_zero got %0d expected 2", bus.cur_len); end
        write_len(4'd15);
        checks++; if (bus.cur_len !== 4'd8) begin errors++; $display("[TB] FAIL len_clamp got %0d expected 8", bus.cur_len); end
    endtask

    task automatic test_reset_midseq();
        logic [2:0] s [5] = '{3'd1, 3'd5, 3'd6, 3'd0, 3'd6};
        program8();
        for (int i = 0; i < 5; i++) begin
            send_sym(s[i]);
            checks++; if (bus.seq_found !== 1'b0) begin errors++; $display("[TB] FAIL mid_sym%0d got %b expected 0", i, bus.seq_found); end
        end
        @(negedge clk); rst = 1'b1;
        #1;
        checks++; if (bus.seq_found !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_found got %b expected 0", bus.seq_found); end
        checks++; if (bus.match_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_rst_count got %0d expected 0", bus.match_count); end
        checks++; if (bus.cur_len !== 4'd1) begin errors++; $display("[TB] FAIL mid_rst_len got %0d expected 1", bus.cur_len); end
        @(negedge clk); rst = 1'b0;
        send_sym(3'd0);
        checks++; if (bus.seq_found !== 1'b1) begin errors++; $display("[TB] FAIL mid_len1_match got %b expected 1", bus.seq_found); end
        checks++; if (bus.match_count !== 16'd1) begin errors++; $display("[TB] FAIL mid_len1_count got %0d expected 1", bus.match_count); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        bus2.overlap = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); bus2.in_valid = 1'b1; bus2.data = 3'd0;
            @(posedge clk); #1; bus2.in_valid = 1'b0;
            checks++; if (bus2.seq_found !== 1'b1) begin errors++; $display("[TB] FAIL sat_found%0d got %b expected 1", i, bus2.seq_found); end
            checks++; if (bus2.match_count !== exp[i]) begin errors++; $display("[TB] FAIL sat_count%0d got %0d expected %0d", i, bus2.match_count, exp[i]); end
        end
        @(negedge clk); bus2.in_valid = 1'b1; bus2.data = 3'd0; bus2.clr_count = 1'b1;
        @(posedge clk); #1; bus2.in_valid = 1'b0; bus2.clr_count = 1'b0;
        checks++; if (bus2.match_count !== 2'd1) begin errors++; $display("[TB] FAIL sat_clr_match got %0d expected 1", bus2.match_count); end
        @(negedge clk); bus2.clr_count = 1'b1;
        @(posedge clk); #1; bus2.clr_count = 1'b0;
        checks++; if (bus2.match_count !== 2'd0) begin errors++; $display("[TB] FAIL sat_clr_only got %0d expected 0", bus2.match_count); end
        checks++; if (bus2.seq_found !== 1'b0) begin errors++; $display("[TB] FAIL sat_clr_found got %b expected 0", bus2.seq_found); end
        @(negedge clk); bus2.in_valid = 1'b1; bus2.data = 3'd5;
        @(posedge clk); #1; bus2.in_valid = 1'b0;
        checks++; if (bus2.seq_found !== 1'b0) begin errors++; $display("[TB] FAIL sat_nomatch got %b expected 0", bus2.seq_found); end
        checks++; if (bus2.match_count !== 2'd0) begin errors++; $display("[TB] FAIL sat_nomatch_count got %0d expected 0", bus2.match_count); end
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_full_pattern();
        test_overlap();
        test_gap_enable();
        test_cfg_collision();
        test_reset_midseq();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
